// File: rtl/uart_rx_oversampled_if.sv
// Serial-line input and received-word output bundle of the oversampling UART receiver.
// The receiver side uses modport master; the driving/observing side uses modport slave.
interface uart_rx_oversampled_if;
  logic       serialdata_in;
  logic       parity_type;
  logic [7:0] parallel_dataout;
  logic       rx_valid;
  logic       parity_error;
  logic       framing_error;
  logic       rx_busy;

  modport master (
    input  serialdata_in,
    input  parity_type,
    output parallel_dataout,
    output rx_valid,
    output parity_error,
    output framing_error,
    output rx_busy
  );

  modport slave (
    output serialdata_in,
    output parity_type,
    input  parallel_dataout,
    input  rx_valid,
    input  parity_error,
    input  framing_error,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 2-flop input synchroniser, free-running baud tick,
// 3-sample majority vote around the bit centre, and a frame FSM that delivers each
// word with parity/framing status on a one-cycle rx_valid strobe.
module uart_rx_oversampled #(
  parameter int unsigned Data_length = 8,   // 5..8 data bits, LSB first
  parameter bit          parity_en   = 1'b0,
  parameter int unsigned OVERSAMPLE  = 16,  // ticks per bit, >= 8 and even
  parameter int unsigned BAUD_DIV    = 27   // rx_clk cycles per tick, >= 2
) (
  input logic                   rx_clk,
  input logic                   rst,
  uart_rx_oversampled_if.master bus
);

  localparam int unsigned ScW = $clog2(OVERSAMPLE);
  localparam int unsigned BdW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [ScW-1:0] ScLast = ScW'(OVERSAMPLE - 1);
  localparam logic [ScW-1:0] ScS0   = ScW'(OVERSAMPLE / 2 - 1);
  localparam logic [ScW-1:0] ScS1   = ScW'(OVERSAMPLE / 2);
  localparam logic [ScW-1:0] ScDec  = ScW'(OVERSAMPLE / 2 + 1);
  localparam logic [BdW-1:0] BdLast = BdW'(BAUD_DIV - 1);
  localparam logic [2:0]     BitLast = 3'(Data_length - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  logic [1:0]     sync_q;
  logic           line;
  logic [BdW-1:0] baud_q;
  logic           tick;

  state_e         state_q;
  logic           armed_q;
  logic [ScW-1:0] sc_q;
  logic [2:0]     bit_cnt_q;
  logic [1:0]     vote_q;
  logic [7:0]     shift_q;
  logic           mismatch_q;
  logic           maj;

  logic [7:0]     data_q;
  logic           valid_q;
  logic           perr_q;
  logic           ferr_q;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.serialdata_in};
    end
  end

  assign line = sync_q[1];

  // Free-running tick divider, never re-aligned to the line.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      baud_q <= '0;
    end else if (baud_q == BdLast) begin
      baud_q <= '0;
    end else begin
      baud_q <= baud_q + BdW'(1);
    end
  end

  assign tick = (baud_q == BdLast);

  // Two stored samples plus the live line sample on the decision tick.
  assign maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & line) | (vote_q[1] & line);

  // Frame FSM with registered outputs; everything advances only on ticks.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      armed_q    <= 1'b1;
      sc_q       <= '0;
      bit_cnt_q  <= '0;
      vote_q     <= '0;
      shift_q    <= '0;
      mismatch_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        // Common per-bit bookkeeping; transitions below override sc_q where needed.
        if (state_q != StIdle) begin
          sc_q <= (sc_q == ScLast) ? '0 : sc_q + ScW'(1);
          if (sc_q == ScS0) vote_q[0] <= line;
          if (sc_q == ScS1) vote_q[1] <= line;
        end
        unique case (state_q)
          StIdle: begin
            if (line) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              // The detect tick itself is sample index 0.
              state_q    <= StStart;
              sc_q       <= ScW'(1);
              shift_q    <= '0;
              mismatch_q <= 1'b0;
            end
          end
          StStart: begin
            if (sc_q == ScDec && maj) begin
              // Glitch: drop back without touching any output.
              state_q <= StIdle;
              sc_q    <= '0;
            end else if (sc_q == ScLast) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            if (sc_q == ScDec) shift_q[bit_cnt_q] <= maj;
            if (sc_q == ScLast) begin
              if (bit_cnt_q == BitLast) begin
                state_q <= parity_en ? StParity : StStop;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          StParity: begin
            if (sc_q == ScDec) mismatch_q <= (^shift_q) ^ maj ^ bus.parity_type;
            if (sc_q == ScLast) state_q <= StStop;
          end
          StStop: begin
            // Leave mid-bit so a start bit right after the stop bit is not lost.
            if (sc_q == ScDec) begin
              state_q <= StIdle;
              sc_q    <= '0;
              armed_q <= 1'b0;
              data_q  <= shift_q;
              ferr_q  <= ~maj;
              perr_q  <= parity_en ? mismatch_q : 1'b0;
              valid_q <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            sc_q    <= '0;
          end
        endcase
      end
    end
  end

  assign bus.parallel_dataout = data_q;
  assign bus.rx_valid         = valid_q;
  assign bus.parity_error     = perr_q;
  assign bus.framing_error    = ferr_q;
  assign bus.rx_busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Randomised and directed frames into two receivers (8N1 and 8E/O1); a queue of
// expected frames computed from the transmitted bits is checked by one monitor.
module tb_uart_rx_oversampled;

  localparam int Bit = 64;  // BAUD_DIV 4 * OVERSAMPLE 16

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_oversampled_if bus0 ();
  uart_rx_oversampled_if bus1 ();

  uart_rx_oversampled #(
    .Data_length(8), .parity_en(1'b0), .OVERSAMPLE(16), .BAUD_DIV(4)
  ) u_dut (
    .rx_clk(clk), .rst(rst), .bus(bus0)
  );

  uart_rx_oversampled #(
    .Data_length(8), .parity_en(1'b1), .OVERSAMPLE(16), .BAUD_DIV(4)
  ) u_dut_p (
    .rx_clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    longint     start;
    int         lat;
    bit         chk_lat;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] hd[2];
  logic       hp[2];
  logic       hf[2];
  int         vcnt[2];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo,
                         input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Checks one receiver against the expected-frame queue and the held outputs.
  task automatic mon(input int idx, input logic v, input logic [7:0] d, input logic pe,
                     input logic fe, input logic busy);
    exp_t e;
    bit   have;
    if (v) begin
      vcnt[idx]++;
      have = (idx == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid dut%0d: actual=1 expected=0", idx);
      end else begin
        if (idx == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("data_dut%0d", idx), d, e.data);
        chk($sformatf("parity_error_dut%0d", idx), pe, e.perr);
        chk($sformatf("framing_error_dut%0d", idx), fe, e.ferr);
        chk($sformatf("busy_at_valid_dut%0d", idx), busy, 0);
        if (e.chk_lat)
          chk_rng($sformatf("latency_dut%0d", idx), cyc - e.start, e.lat * 4 + 3,
                  e.lat * 4 + 6);
        hd[idx] = e.data;
        hp[idx] = e.perr;
        hf[idx] = e.ferr;
      end
    end else begin
      chk($sformatf("hold_dut%0d", idx), {d, pe, fe}, {hd[idx], hp[idx], hf[idx]});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        hd[i] = 8'h00;
        hp[i] = 1'b0;
        hf[i] = 1'b0;
      end
    end else begin
      mon(0, bus0.rx_valid, bus0.parallel_dataout, bus0.parity_error, bus0.framing_error,
          bus0.rx_busy);
      mon(1, bus1.rx_valid, bus1.parallel_dataout, bus1.parity_error, bus1.framing_error,
          bus1.rx_busy);
    end
  end

  task automatic drive(input int idx, input logic v);
    if (idx == 0) bus0.serialdata_in = v;
    else bus1.serialdata_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Transmits one frame and queues what the receiver must report for it.
  task automatic send(input int idx, input logic [7:0] d, input bit pen, input logic pbit,
                      input logic ptype, input logic stop, input int bp, input bit lat_on);
    exp_t e;
    logic busy;
    e.data    = d;
    e.perr    = pen ? ((^d) ^ pbit ^ ptype) : 1'b0;
    e.ferr    = ~stop;
    e.start   = cyc;
    e.lat     = (9 + int'(pen)) * 16 + 9;
    e.chk_lat = lat_on;
    if (idx == 1) bus1.parity_type = ptype;
    if (idx == 0) q0.push_back(e);
    else q1.push_back(e);
    drive(idx, 1'b0);
    idle(bp);
    for (int i = 0; i < 8; i++) begin
      drive(idx, d[i]);
      if (i == 3) begin
        idle(bp / 2);
        busy = (idx == 0) ? bus0.rx_busy : bus1.rx_busy;
        chk($sformatf("busy_midframe_dut%0d", idx), busy, 1);
        idle(bp - bp / 2);
      end else begin
        idle(bp);
      end
    end
    if (pen) begin
      drive(idx, pbit);
      idle(bp);
    end
    drive(idx, stop);
    idle(bp);
    drive(idx, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data0"}, bus0.parallel_dataout, 8'h00);
    chk({tag, "_flags0"}, {bus0.rx_valid, bus0.parity_error, bus0.framing_error,
                           bus0.rx_busy}, 4'b0000);
    chk({tag, "_data1"}, bus1.parallel_dataout, 8'h00);
    chk({tag, "_flags1"}, {bus1.rx_valid, bus1.parity_error, bus1.framing_error,
                           bus1.rx_busy}, 4'b0000);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int gap;
    int idx;
    logic [7:0] d;
    logic pb;
    logic pt;
    logic st;

    vcnt[0] = 0;
    vcnt[1] = 0;
    bus0.serialdata_in = 1'b1;
    bus1.serialdata_in = 1'b1;
    bus0.parity_type   = 1'b0;
    bus1.parity_type   = 1'b0;
    idle(5);
    chk_reset_outputs("reset");
    rst = 1'b0;
    idle(2 * Bit);

    // Single 8N1 frame.
    send(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, Bit, 1'b1);
    drain();
    chk("a5_data", bus0.parallel_dataout, 8'hA5);
    chk("a5_flags", {bus0.parity_error, bus0.framing_error, bus0.rx_busy}, 3'b000);
    chk("a5_count", vcnt[0], 1);
    idle(Bit);

    // Even parity: correct then wrong parity bit.
    send(1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, Bit, 1'b1);
    drain();
    chk("par_ok", bus1.parity_error, 1'b0);
    idle(Bit);
    send(1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, Bit, 1'b1);
    drain();
    chk("par_bad_flag", bus1.parity_error, 1'b1);
    chk("par_bad_data", bus1.parallel_dataout, 8'h3C);
    idle(Bit);

    // Break: 20 bit times low gives exactly one all-zero frame with framing error.
    begin
      exp_t e;
      e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b1; e.start = cyc; e.lat = 153;
      e.chk_lat = 1'b1;
      q0.push_back(e);
    end
    base = vcnt[0];
    drive(0, 1'b0);
    idle(20 * Bit);
    chk("break_count", vcnt[0] - base, 1);
    chk("break_ferr", bus0.framing_error, 1'b1);
    chk("break_data", bus0.parallel_dataout, 8'h00);
    drive(0, 1'b1);
    idle(2 * Bit);
    send(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, Bit, 1'b1);
    drain();
    chk("after_break_ferr", bus0.framing_error, 1'b0);
    idle(Bit);

    // Glitches of 1 and 4 ticks must not produce frames.
    base = vcnt[0];
    drive(0, 1'b0); idle(4);
    drive(0, 1'b1); idle(2 * Bit);
    drive(0, 1'b0); idle(16);
    drive(0, 1'b1); idle(2 * Bit);
    chk("glitch_count", vcnt[0] - base, 0);
    send(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, Bit, 1'b1);
    drain();
    chk("after_glitch_data", bus0.parallel_dataout, 8'h81);
    idle(Bit);

    // Back-to-back streaming at +3% and -3% transmitter rate.
    for (int s = 0; s < 2; s++) begin
      base = vcnt[0];
      for (int v = 0; v < 16; v++)
        send(0, 8'(v), 1'b0, 1'b0, 1'b0, 1'b1, (s == 0) ? 62 : 66, 1'b0);
      drain();
      chk($sformatf("stream_count_%0d", s), vcnt[0] - base, 16);
      idle(Bit);
    end

    // Reset in the middle of bit 4 of 0xFF.
    base = vcnt[0];
    drive(0, 1'b0); idle(Bit);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1); idle(Bit);
    end
    idle(Bit / 2);
    chk("busy_before_reset", bus0.rx_busy, 1'b1);
    rst = 1'b1;
    idle(3);
    chk_reset_outputs("midreset");
    rst = 1'b0;
    idle(Bit / 2 + 4 * Bit);
    chk("reset_frame_count", vcnt[0] - base, 0);
    idle(Bit);
    send(0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, Bit, 1'b1);
    drain();
    chk("after_reset_data", bus0.parallel_dataout, 8'h12);
    idle(Bit);

    // Random frames on both receivers, with occasional bad stop bits.
    for (int r = 0; r < 30; r++) begin
      idx = int'($urandom_range(1, 0));
      d   = 8'($urandom);
      pb  = 1'($urandom);
      pt  = 1'($urandom);
      st  = ($urandom_range(7, 0) != 0);
      gap = st ? int'($urandom_range(80, 0)) : int'($urandom_range(80, 16));
      send(idx, d, idx == 1, pb, pt, st, Bit, 1'b1);
      idle(gap);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
